// File: rtl/bullet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bullet_pkg                                                |
// | Purpose  : Shared types and default constants for the player bullet  |
// |            pool controller and its slot allocator.                   |
// | Contents : trig_state_e         trigger FSM state encoding           |
// |            DEFAULT_PRESS_THRESH ADC level below which button pressed |
// |            DEFAULT_COOLDOWN     default cycles between two fires     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package bullet_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StHeld = 1'b1
   } trig_state_e;

   localparam logic [12:0] DEFAULT_PRESS_THRESH = 13'h0200;
   localparam int          DEFAULT_COOLDOWN     = 8;

endpackage
`default_nettype wire

// File: rtl/slot_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : slot_alloc                                                |
// | Purpose  : Combinational priority encoder returning the lowest-index |
// |            free (non-busy) bullet slot.                              |
// | Ports    : busy_i     [N]     slot occupied flags                    |
// |            any_free_o [1]     at least one slot is free              |
// |            idx_o      [IDX_W] lowest free slot (0 when none free)    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module slot_alloc
   import bullet_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     busy_i,
   output logic             any_free_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from the top down so the last assignment is the lowest free slot.
   always_comb begin
      any_free_o = ~&busy_i;
      idx_o      = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bullet_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bullet_pool_ctrl                                          |
// | Purpose  : Player bullet-slot manager. Turns the button ADC sample   |
// |            into fire requests (semi- or full-auto), enforces a fire  |
// |            cooldown, spawns into the lowest free slot and retires    |
// |            slots on enemy hit or screen exit.                        |
// | Ports    : clk_i        [1]     system clock                         |
// |            reset_i      [1]     async active-high reset              |
// |            rdata3_i     [ADC_W] button ADC sample                    |
// |            bhit_i       [NB]    per-slot enemy hit pulse             |
// |            bexit_i      [NB]    per-slot bullet left the screen      |
// |            bdisplay_o   [NB]    slot active                          |
// |            fire_o       [1]     one-cycle spawn pulse                |
// |            fire_idx_o   [IDX_W] spawned slot, valid with fire_o      |
// |            active_cnt_o [CNT_W] number of active slots               |
// |            cooldown_o   [1]     cooldown counter non-zero            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bullet_pool_ctrl
   import bullet_pkg::*;
#(
   parameter int               NUM_BULLETS  = 4,
   parameter int               ADC_W        = 13,
   parameter logic [ADC_W-1:0] PRESS_THRESH = ADC_W'(DEFAULT_PRESS_THRESH),
   parameter int               COOLDOWN_CYC = DEFAULT_COOLDOWN,
   parameter int               AUTO_FIRE    = 0,
   localparam int              IDX_W        = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
   localparam int              CNT_W        = $clog2(NUM_BULLETS + 1)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [ADC_W-1:0]       rdata3_i,
   input  logic [NUM_BULLETS-1:0] bhit_i,
   input  logic [NUM_BULLETS-1:0] bexit_i,
   output logic [NUM_BULLETS-1:0] bdisplay_o,
   output logic                   fire_o,
   output logic [IDX_W-1:0]       fire_idx_o,
   output logic [CNT_W-1:0]       active_cnt_o,
   output logic                   cooldown_o
);

   localparam int              CD_W    = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYC - 1);

   trig_state_e            state_q;
   logic [NUM_BULLETS-1:0] bdisplay_q, bdisplay_d;
   logic                   fire_q;
   logic [IDX_W-1:0]       fire_idx_q;
   logic [CD_W-1:0]        cd_q, cd_d;
   logic                   cooldown_q;
   logic [CNT_W-1:0]       active_cnt_q, active_cnt_d;

   logic                   pressed;
   logic                   fire_req;
   logic                   accept;
   logic                   any_free;
   logic [IDX_W-1:0]       free_idx;

   // Free slots come from the registered vector only, so a slot retiring
   // this cycle cannot be reused until the next one.
   slot_alloc #(
      .N     (NUM_BULLETS),
      .IDX_W (IDX_W)
   ) u_slot_alloc (
      .busy_i     (bdisplay_q),
      .any_free_o (any_free),
      .idx_o      (free_idx)
   );

   always_comb begin
      pressed  = (rdata3_i < PRESS_THRESH);
      // Semi-auto only asks on the press edge; a refused shot is lost
      // because the FSM still advances to StHeld.
      fire_req = (AUTO_FIRE != 0) ? pressed : (pressed && (state_q == StIdle));
      accept   = fire_req && (cd_q == '0) && any_free;

      bdisplay_d = bdisplay_q & ~(bhit_i | bexit_i);
      if (accept) begin
         bdisplay_d[free_idx] = 1'b1;
      end

      if (accept) begin
         cd_d = CD_LOAD;
      end else if (cd_q != '0) begin
         cd_d = cd_q - CD_W'(1);
      end else begin
         cd_d = cd_q;
      end

      active_cnt_d = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         active_cnt_d = active_cnt_d + CNT_W'(bdisplay_d[i]);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         bdisplay_q   <= '0;
         fire_q       <= 1'b0;
         fire_idx_q   <= '0;
         cd_q         <= '0;
         cooldown_q   <= 1'b0;
         active_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle:  if (pressed)  state_q <= StHeld;
            StHeld:  if (!pressed) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         bdisplay_q   <= bdisplay_d;
         fire_q       <= accept;
         if (accept) begin
            fire_idx_q <= free_idx;
         end
         cd_q         <= cd_d;
         // Mirrors the counter's next value so the flag is aligned with it.
         cooldown_q   <= (cd_d != '0);
         active_cnt_q <= active_cnt_d;
      end
   end

   assign bdisplay_o   = bdisplay_q;
   assign fire_o       = fire_q;
   assign fire_idx_o   = fire_idx_q;
   assign active_cnt_o = active_cnt_q;
   assign cooldown_o   = cooldown_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bullet_pool_ctrl                                       |
// | Purpose  : Directed bench for bullet_pool_ctrl. One instance is      |
// |            semi-auto with cooldown 8, the other full-auto with       |
// |            cooldown 4.                                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_bullet_pool_ctrl;

   localparam logic [12:0] REL = 13'h0FFF;
   localparam logic [12:0] PRS = 13'h0100;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // semi-auto instance
   logic        reset_s;
   logic [12:0] rdata_s;
   logic [3:0]  hit_s, exit_s, bdisp_s;
   logic        fire_s, cd_s;
   logic [1:0]  idx_s;
   logic [2:0]  cnt_s;

   // full-auto instance
   logic        reset_a;
   logic [12:0] rdata_a;
   logic [3:0]  hit_a, exit_a, bdisp_a;
   logic        fire_a, cd_a;
   logic [1:0]  idx_a;
   logic [2:0]  cnt_a;

   int checks = 0;
   int errors = 0;
   int nf;
   logic [1:0] last_idx;

   bullet_pool_ctrl #(
      .NUM_BULLETS (4), .ADC_W (13), .PRESS_THRESH (13'h0200),
      .COOLDOWN_CYC (8), .AUTO_FIRE (0)
   ) dut_s (
      .clk_i (clk), .reset_i (reset_s), .rdata3_i (rdata_s),
      .bhit_i (hit_s), .bexit_i (exit_s), .bdisplay_o (bdisp_s),
      .fire_o (fire_s), .fire_idx_o (idx_s), .active_cnt_o (cnt_s),
      .cooldown_o (cd_s)
   );

   bullet_pool_ctrl #(
      .NUM_BULLETS (4), .ADC_W (13), .PRESS_THRESH (13'h0200),
      .COOLDOWN_CYC (4), .AUTO_FIRE (1)
   ) dut_a (
      .clk_i (clk), .reset_i (reset_a), .rdata3_i (rdata_a),
      .bhit_i (hit_a), .bexit_i (exit_a), .bdisplay_o (bdisp_a),
      .fire_o (fire_a), .fire_idx_o (idx_a), .active_cnt_o (cnt_a),
      .cooldown_o (cd_a)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_s = 1'b1; rdata_s = REL; hit_s = '0; exit_s = '0;
      reset_a = 1'b1; rdata_a = PRS; hit_a = '0; exit_a = '0;
      tick(); tick();

      // reset state
      chk("rst_bdisp", bdisp_s, 4'b0000);
      chk("rst_fire",  fire_s,  0);
      chk("rst_cnt",   cnt_s,   0);
      chk("rst_cd",    cd_s,    0);
      chk("rst_idx",   idx_s,   0);
      reset_s = 1'b0;
      tick();
      chk("idle_bdisp", bdisp_s, 4'b0000);

      // semi-auto: held 40 cycles gives exactly one shot
      rdata_s = PRS;
      nf = 0; last_idx = 2'd3;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (fire_s) begin
            nf++;
            last_idx = idx_s;
         end
      end
      chk("hold_nfire", nf, 1);
      chk("hold_idx",   last_idx, 0);
      chk("hold_bdisp", bdisp_s, 4'b0001);
      chk("hold_cnt",   cnt_s, 1);

      rdata_s = REL;
      tick();
      for (int k = 1; k <= 3; k++) begin
         rdata_s = PRS;
         tick();
         chk("press_fire", fire_s, 1);
         chk("press_idx",  idx_s, k);
         chk("press_cd",   cd_s, 1);
         repeat (4) tick();
         rdata_s = REL;
         repeat (5) tick();
      end
      chk("fill_bdisp", bdisp_s, 4'b1111);
      chk("fill_cnt",   cnt_s, 4);

      // pool full: press dropped; hit frees slot 1 and next press refills it
      rdata_s = PRS;
      nf = 0;
      repeat (5) begin
         tick();
         if (fire_s) nf++;
      end
      chk("full_nfire", nf, 0);
      chk("full_bdisp", bdisp_s, 4'b1111);
      rdata_s = REL;
      repeat (2) tick();
      hit_s = 4'b0010;
      tick();
      hit_s = '0;
      chk("hit1_bdisp", bdisp_s, 4'b1101);
      chk("hit1_cnt",   cnt_s, 3);
      rdata_s = PRS;
      tick();
      chk("refill_fire",  fire_s, 1);
      chk("refill_idx",   idx_s, 1);
      chk("refill_bdisp", bdisp_s, 4'b1111);
      rdata_s = REL;
      repeat (10) tick();

      // same-cycle exit of slot 0 and fire: new bullet lands in slot 1
      exit_s = 4'b1111;
      tick();
      exit_s = '0;
      chk("exitall_bdisp", bdisp_s, 4'b0000);
      chk("exitall_cnt",   cnt_s, 0);
      rdata_s = PRS;
      tick();
      chk("s0_idx",   idx_s, 0);
      chk("s0_bdisp", bdisp_s, 4'b0001);
      rdata_s = REL;
      repeat (10) tick();
      exit_s = 4'b0001; rdata_s = PRS;
      tick();
      exit_s = '0;
      chk("same_fire",  fire_s, 1);
      chk("same_idx",   idx_s, 1);
      chk("same_bdisp", bdisp_s, 4'b0010);
      rdata_s = REL;
      tick();
      hit_s = 4'b0100;
      tick();
      hit_s = '0;
      chk("inact_bdisp", bdisp_s, 4'b0010);
      chk("inact_cnt",   cnt_s, 1);

      // cooldown boundary: re-press at t+3 dropped, press at t+8 accepted
      exit_s = 4'b1111;
      tick();
      exit_s = '0;
      repeat (10) tick();
      rdata_s = PRS;
      tick();
      chk("cdb_fire0", fire_s, 1);
      chk("cdb_idx0",  idx_s, 0);
      chk("cdb_cd0",   cd_s, 1);
      rdata_s = REL;
      tick(); tick();
      rdata_s = PRS;
      tick();
      chk("cdb_drop_fire", fire_s, 0);
      chk("cdb_drop_cd",   cd_s, 1);
      tick();
      chk("cdb_t4_fire", fire_s, 0);
      tick();
      chk("cdb_t5_fire", fire_s, 0);
      rdata_s = REL;
      tick();
      chk("cdb_t6_cd", cd_s, 1);
      tick();
      chk("cdb_t7_cd", cd_s, 0);
      rdata_s = PRS;
      tick();
      chk("cdb_t8_fire",  fire_s, 1);
      chk("cdb_t8_idx",   idx_s, 1);
      chk("cdb_t8_bdisp", bdisp_s, 4'b0011);
      rdata_s = REL;

      // full-auto, cooldown 4, held from release of reset
      reset_a = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk("auto_fire", fire_a, ((c % 4) == 1 && c <= 13) ? 1 : 0);
         if ((c % 4) == 1 && c <= 13) begin
            chk("auto_idx", idx_a, (c - 1) / 4);
         end
      end
      chk("auto_bdisp", bdisp_a, 4'b1111);
      chk("auto_cnt",   cnt_a, 4);
      hit_a = 4'b0100;
      tick();
      hit_a = '0;
      chk("auto_hit_bdisp", bdisp_a, 4'b1011);
      chk("auto_hit_fire",  fire_a, 0);
      tick();
      chk("auto_retry_fire",  fire_a, 1);
      chk("auto_retry_idx",   idx_a, 2);
      chk("auto_retry_bdisp", bdisp_a, 4'b1111);

      // asynchronous reset mid-flight, away from any clock edge
      reset_a = 1'b1;
      #1;
      chk("async_bdisp", bdisp_a, 4'b0000);
      chk("async_cnt",   cnt_a, 0);
      chk("async_fire",  fire_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bullet_pool_ctrl.md
Name: bullet_pool_ctrl

Overview:
Parametrised bullet-slot manager for the player ship. It generalises the two-bullet display FSM to NUM_BULLETS slots. It adds a fire-rate cooldown, a semi-auto or full-auto trigger mode, off-screen retirement and a spawn pulse with a slot index. It sits between the joystick/button ADC readback (rdata3) and the per-slot bullet position and collision logic.

Parameters:
NUM_BULLETS, 4, number of bullet slots (>=1)
ADC_W, 13, width of the button ADC sample
PRESS_THRESH, 13'h0200, sample strictly below this value means pressed
COOLDOWN_CYC, 8, minimum clk_i cycles between two fires (>=1)
AUTO_FIRE, 0, 0 = semi-auto (one shot per press), 1 = full-auto (repeat while held)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
rdata3_i  in  ADC_W  button ADC sample
bhit_i  in  NUM_BULLETS  per-slot enemy hit, one-cycle pulse
bexit_i  in  NUM_BULLETS  per-slot bullet left the screen
bdisplay_o  out  NUM_BULLETS  slot active; drives display and motion
fire_o  out  1  one-cycle pulse, a bullet was spawned
fire_idx_o  out  max(1,$clog2(NUM_BULLETS))  slot spawned; valid while fire_o is high
active_cnt_o  out  $clog2(NUM_BULLETS+1)  popcount of bdisplay_o
cooldown_o  out  1  cooldown counter is non-zero

Behaviour:
- Reset (async, active-high): bdisplay_o=0, fire_o=0, fire_idx_o=0, active_cnt_o=0, cooldown_o=0. Trigger FSM goes to StIdle. Cooldown counter goes to 0. Reset mid-flight kills all bullets immediately.
- All outputs are registered. active_cnt_o and cooldown_o are derived from registers.
- pressed = (rdata3_i < PRESS_THRESH), evaluated combinationally each cycle.
- Trigger FSM, states StIdle and StHeld:
  - StIdle: pressed -> StHeld.
  - StHeld: !pressed -> StIdle.
- Fire request:
  - AUTO_FIRE=0: asserted when state==StIdle and pressed (press edge only).
  - AUTO_FIRE=1: asserted whenever pressed.
- Fire accept requires all three: the request, cooldown==0, and at least one free slot (bdisplay_o bit == 0).
- On accept at edge t:
  - The lowest-index free slot is set.
  - fire_o=1 and fire_idx_o=slot during the cycle after t.
  - The cooldown counter loads COOLDOWN_CYC-1.
- Non-zero cooldown counter decrements by 1 per cycle. The next fire is possible no earlier than edge t+COOLDOWN_CYC.
- Dropped shots in semi-auto: a request refused because of a full pool or cooldown is lost. The player must release and press again. The FSM still moves to StHeld.
- In full-auto, a refused request simply retries every cycle while pressed.
- Slot clear: bhit_i[i] | bexit_i[i] clears bit i at the next edge. Hit or exit on an already-inactive slot is ignored.
- Same-cycle fire and clear: free slots are computed from the current registered bdisplay_o. A slot being cleared this cycle is not reusable until the following cycle. Clears of other slots and a fire all take effect at the same edge.
- Simultaneous hits on several slots all clear at the same edge.
- active_cnt_o equals popcount(bdisplay_o), updated in the same cycle as bdisplay_o.

Decomposition:
- Package bullet_pkg holds:
  - typedef trig_state_e {StIdle, StHeld}
  - localparam DEFAULT_PRESS_THRESH = 13'h0200
  - localparam DEFAULT_COOLDOWN = 8
- Sub-module slot_alloc: combinational lowest-index-free priority encoder. Inputs: busy vector. Outputs: any_free and idx. Instantiated once.

Test Plan:
1. Reset with rdata3_i=13'h0FFF -> bdisplay_o=0000, fire_o=0, active_cnt_o=0. Asserting reset_i with slots active clears them asynchronously.
2. Semi-auto, COOLDOWN_CYC=8: hold rdata3_i=13'h0100 for 40 cycles -> exactly one fire_o pulse, fire_idx_o=0, bdisplay_o=0001. Then release and press three more times, 10 cycles apart -> slots 1,2,3 fill and bdisplay_o=1111.
3. Pool full: a fifth press -> no fire_o, no change. Pulse bhit_i[1] -> bdisplay_o=1101. The next press spawns into slot 1.
4. Full-auto, COOLDOWN_CYC=4, held pressed from cycle 0 -> fire_o at cycles 1, 5, 9, 13 with idx 0,1,2,3. No further fires until a slot is cleared.
5. Same cycle: bexit_i[0]=1 and fire request with bdisplay_o=0001 -> new bullet goes to slot 1 and slot 0 clears, giving bdisplay_o=0010. Hit on an inactive slot 2 -> no change.
6. Cooldown boundary, semi-auto, COOLDOWN_CYC=8: re-press 3 cycles after a fire -> shot dropped, cooldown_o=1. Re-press after 8 cycles -> shot accepted.
